// File: rtl/label_packer.sv
// Packs an unthrottled 8-bit label stream into 64-bit little-endian AXIS words,
// buffering them in a small FIFO and flagging any word lost to backpressure.
module label_packer #(
   parameter int unsigned IN_WIDTH   = 8,
   parameter int unsigned LANES_OUT  = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [IN_WIDTH-1:0]           s_tdata,
   input  logic                          s_tvalid,
   input  logic                          s_tlast,
   output logic [IN_WIDTH*LANES_OUT-1:0] m_tdata,
   output logic [LANES_OUT-1:0]          m_tkeep,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic                          m_tlast,
   input  logic                          clr_status,
   output logic                          overflow,
   output logic [CNT_WIDTH-1:0]          words_sent,
   output logic [CNT_WIDTH-1:0]          frames_sent
);

   localparam int unsigned OUT_W = IN_WIDTH * LANES_OUT;
   localparam int unsigned IDX_W = (LANES_OUT > 1) ? $clog2(LANES_OUT) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [OUT_W-1:0]     pack_q;
   logic [OUT_W-1:0]     pack_word;
   logic [LANES_OUT-1:0] pack_keep;
   logic [IDX_W-1:0]     idx_q;
   logic                 word_done;

   logic [OUT_W-1:0]     mem_data [FIFO_DEPTH];
   logic [LANES_OUT-1:0] mem_keep [FIFO_DEPTH];
   logic                 mem_last [FIFO_DEPTH];
   logic [PTR_W:0]       wr_ptr;
   logic [PTR_W:0]       rd_ptr;
   logic                 empty;
   logic                 full;
   logic                 pop;
   logic                 push_ok;
   logic                 drop;

   // Completed word is the pack register with the current byte merged into lane idx.
   always_comb begin
      pack_word = pack_q;
      pack_keep = '0;
      for (int unsigned i = 0; i < LANES_OUT; i++) begin
         if (IDX_W'(i) == idx_q) pack_word[i*IN_WIDTH +: IN_WIDTH] = s_tdata;
         pack_keep[i] = (IDX_W'(i) <= idx_q);
      end
      word_done = s_tvalid && ((idx_q == IDX_W'(LANES_OUT - 1)) || s_tlast);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pack_q <= '0;
         idx_q  <= '0;
      end else if (s_tvalid) begin
         if (word_done) begin
            pack_q <= '0;
            idx_q  <= '0;
         end else begin
            pack_q <= pack_word;
            idx_q  <= idx_q + IDX_W'(1);
         end
      end
   end

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop     = !empty && m_tready;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push_ok = word_done && (!full || pop);
   assign drop    = word_done && full && !pop;

   always_ff @(posedge aclk) begin
      if (push_ok) begin
         mem_data[wr_ptr[PTR_W-1:0]] <= pack_word;
         mem_keep[wr_ptr[PTR_W-1:0]] <= pack_keep;
         mem_last[wr_ptr[PTR_W-1:0]] <= s_tlast;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   assign m_tvalid = !empty;
   assign m_tdata  = empty ? '0 : mem_data[rd_ptr[PTR_W-1:0]];
   assign m_tkeep  = empty ? '0 : mem_keep[rd_ptr[PTR_W-1:0]];
   assign m_tlast  = empty ? 1'b0 : mem_last[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow    <= 1'b0;
         words_sent  <= '0;
         frames_sent <= '0;
      end else if (clr_status) begin
         overflow    <= 1'b0;
         words_sent  <= '0;
         frames_sent <= '0;
      end else begin
         if (drop)           overflow    <= 1'b1;
         if (pop)            words_sent  <= words_sent + CNT_WIDTH'(1);
         if (pop && m_tlast) frames_sent <= frames_sent + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_label_packer.sv
// Scoreboard bench for label_packer: a byte-list reference model predicts the
// accepted words and status; a monitor checks every output handshake.
module tb_label_packer;

   localparam int unsigned LANES = 8;
   localparam int unsigned DEPTH = 16;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        clr_status;
   logic        overflow;
   logic [15:0] words_sent;
   logic [15:0] frames_sent;

   label_packer #(.IN_WIDTH(8), .LANES_OUT(LANES), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .clr_status(clr_status), .overflow(overflow),
      .words_sent(words_sent), .frames_sent(frames_sent)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } word_t;

   word_t       mq[$];   // model of FIFO occupancy
   word_t       sb[$];   // expected words, consumed by the monitor
   logic [7:0]  cur[$];  // bytes of the word being assembled
   logic        m_ovf;
   logic [15:0] m_words;
   logic [15:0] m_frames;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words are built from the list of received bytes.
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         mq.delete(); sb.delete(); cur.delete();
         m_ovf = 1'b0; m_words = '0; m_frames = '0;
      end else begin
         bit    was_full;
         bit    pop;
         word_t w;
         was_full = (mq.size() == DEPTH);
         pop      = (mq.size() > 0) && m_tready;
         if (pop) begin
            m_words++;
            if (mq[0].l) m_frames++;
            void'(mq.pop_front());
         end
         if (s_tvalid) begin
            cur.push_back(s_tdata);
            if (cur.size() == LANES || s_tlast) begin
               w.d = '0; w.k = '0; w.l = s_tlast;
               foreach (cur[i]) begin
                  w.d[i*8 +: 8] = cur[i];
                  w.k[i]        = 1'b1;
               end
               cur.delete();
               if (!was_full || pop) begin
                  mq.push_back(w);
                  sb.push_back(w);
               end else begin
                  m_ovf = 1'b1;
               end
            end
         end
         if (clr_status) begin
            m_ovf = 1'b0; m_words = '0; m_frames = '0;
         end
      end
   end

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge aclk) begin
      if (!aresetn) begin
         chk("rst_tvalid", 64'(m_tvalid), 64'd0);
         chk("rst_tdata", m_tdata, 64'd0);
         chk("rst_tkeep", 64'(m_tkeep), 64'd0);
         chk("rst_tlast", 64'(m_tlast), 64'd0);
         chk("rst_overflow", 64'(overflow), 64'd0);
         chk("rst_words", 64'(words_sent), 64'd0);
         chk("rst_frames", 64'(frames_sent), 64'd0);
      end else begin
         word_t e;
         chk("tvalid", 64'(m_tvalid), 64'(mq.size() > 0));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("words_sent", 64'(words_sent), 64'(m_words));
         chk("frames_sent", 64'(frames_sent), 64'(m_frames));
         if (m_tvalid) chk("tkeep_nonzero", 64'(m_tkeep != 8'h00), 64'd1);
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
               chk("unexpected_word", m_tdata, 64'hx);
            end else begin
               e = sb.pop_front();
               chk("tdata", m_tdata, e.d);
               chk("tkeep", 64'(m_tkeep), 64'(e.k));
               chk("tlast", 64'(m_tlast), 64'(e.l));
            end
         end
      end
   end

   task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit r, input bit c);
      s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r; clr_status = c;
      @(posedge aclk);
      #1;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, r, 1'b0);
   endtask

   task automatic fill_words(input int n);
      for (int i = 0; i < n * 8; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
      m_tready = 1'b0; clr_status = 1'b0;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;

      // 16-label frame, continuous ready
      for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), i == 16, 1'b1, 1'b0);
      idle(4, 1'b1);
      chk("t1_words", 64'(words_sent), 64'd2);
      chk("t1_frames", 64'(frames_sent), 64'd1);

      // short 3-label frame
      cyc(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'd2, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'd1, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);

      // fill FIFO while stalled, then overflow the 17th word
      fill_words(16);
      chk("t3_no_ovf_yet", 64'(overflow), 64'd0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom), i == 7, 1'b0, 1'b0);
      chk("t3_ovf", 64'(overflow), 64'd1);
      idle(20, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      // full FIFO with a pop in the completing cycle
      fill_words(16);
      for (int i = 0; i < 7; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
      chk("t4_no_ovf", 64'(overflow), 64'd0);
      idle(20, 1'b1);

      // reset mid-frame
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      aresetn = 1'b0;
      idle(2, 1'b0);
      aresetn = 1'b1;
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h80 + i), i == 7, 1'b1, 1'b0);
      idle(3, 1'b1);
      chk("t5_words", 64'(words_sent), 64'd1);
      chk("t5_frames", 64'(frames_sent), 64'd1);

      // clear coincident with a tlast handshake
      cyc(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("t6_words", 64'(words_sent), 64'd0);
      chk("t6_frames", 64'(frames_sent), 64'd0);
      chk("t6_ovf", 64'(overflow), 64'd0);

      // randomized traffic with stall phases
      for (int i = 0; i < 4000; i++) begin
         bit stall;
         stall = ((i / 200) % 3 == 1);
         cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 10) == 0,
             stall ? (($urandom % 8) == 0) : (($urandom % 3) != 0),
             ($urandom % 300) == 0);
      end

      // drain with a bounded wait
      for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1, 1'b1);
      idle(2, 1'b1);
      chk("drain_complete", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
